mc_data_path: RTL and testbench

Multi-cycle MIPS datapath with an integrated sequencer: the successor of the single-cycle `Data_path`. It holds the program counter, instruction register, register file and ALU, and steps each instruction through fetch, decode, execute, memory and write-back. Instruction and data memory sit behind one shared request/ready port. The register-file depth, reset vector and memory address width are parameters.

---
 rtl/mc_pkg.sv | 103 ++++++++++
 rtl/mc_data_path_if.sv | 14 +
 rtl/mc_regfile.sv | 33 +++
 rtl/mc_data_path.sv | 202 ++++++++++++++++++++
 tb/tb_mc_data_path.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS datapath: sequencer states,
// opcode/funct encodings, ALU operations and the overflow trap vector.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

    function automatic alu_op_e alu_op_of(input logic [5:0] op, input logic [5:0] funct);
        alu_op_e r;
        r = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_SUB:   r = ALU_SUB;
                    F_AND:   r = ALU_AND;
                    F_OR:    r = ALU_OR;
                    F_SLT:   r = ALU_SLT;
                    default: r = ALU_ADD;
                endcase
            end
            OP_ANDI: r = ALU_AND;
            OP_ORI:  r = ALU_OR;
            OP_SLTI: r = ALU_SLT;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
                    default:                          ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'h0000_0001 : 32'h0000_0000;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic signed_ovf(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] r);
        logic v;
        case (op)
            ALU_ADD: v = (a[31] == b[31]) && (r[31] != a[31]);
            ALU_SUB: v = (a[31] != b[31]) && (r[31] != a[31]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mc_data_path_if.sv
// Shared instruction/data memory port: one request/ready handshake for both fetch and load/store.
interface mc_data_path_if #(parameter int MEM_AW = 32);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr, output mem_wdata,
                    input mem_rdata, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr, input mem_wdata,
                    output mem_rdata, output mem_ready);
endinterface

// File: rtl/mc_regfile.sv
// NREG x 32 register file: two asynchronous read ports, one synchronous write port, r0 fixed at zero.
module mc_regfile #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    localparam int AW = $clog2(NREG);

    logic [31:0] regs_q [NREG];

    // Index bits above log2(NREG) are dropped; r0 is never written so it keeps its reset zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (we_i && (wa_i[AW-1:0] != {AW{1'b0}})) begin
            regs_q[wa_i[AW-1:0]] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i[AW-1:0] == {AW{1'b0}}) ? 32'h0000_0000 : regs_q[ra1_i[AW-1:0]];
    assign rd2_o = (ra2_i[AW-1:0] == {AW{1'b0}}) ? 32'h0000_0000 : regs_q[ra2_i[AW-1:0]];

endmodule

// File: rtl/mc_data_path.sv
// Multi-cycle MIPS datapath with integrated FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define MC_OVERFLOW_TRAP_EN to send overflowing add/sub/addi to TRAP_VECTOR instead of writing back.
module mc_data_path
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32,
    parameter int          MEM_AW   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_data_path_if.master        mem,
    output logic [31:0]           PC_out,
    output logic [31:0]           ALU_out,
    output logic                  zero,
    output logic                  overflow,
    output logic                  illegal,
    output logic [2:0]            state
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic        overflow_q, overflow_d, illegal_q, illegal_d;

    logic [5:0]  opcode_s, funct_s;
    logic [31:0] sext_imm_s, opnd_b_s, alu_res_s, rs_val_s, rt_val_s;
    alu_op_e     alu_op_s;
    logic        is_arith_s, ovf_s;
    logic        rf_we_s;
    logic [4:0]  rf_wa_s;
    logic [31:0] rf_wd_s;

    assign opcode_s   = ir_q[31:26];
    assign funct_s    = ir_q[5:0];
    assign sext_imm_s = {{16{ir_q[15]}}, ir_q[15:0]};
    assign alu_op_s   = alu_op_of(opcode_s, funct_s);
    assign is_arith_s = (opcode_s == OP_ADDI) ||
                        ((opcode_s == OP_RTYPE) && ((funct_s == F_ADD) || (funct_s == F_SUB)));

    // Second ALU operand: rt for R-type, zero-extended imm for andi/ori, sign-extended otherwise.
    always_comb begin
        if (opcode_s == OP_RTYPE) begin
            opnd_b_s = b_q;
        end else if ((opcode_s == OP_ANDI) || (opcode_s == OP_ORI)) begin
            opnd_b_s = {16'h0000, ir_q[15:0]};
        end else begin
            opnd_b_s = sext_imm_s;
        end
    end

    assign alu_res_s = alu_calc(alu_op_s, a_q, opnd_b_s);
    assign ovf_s     = is_arith_s && signed_ovf(alu_op_s, a_q, opnd_b_s, alu_res_s);

    mc_regfile #(.NREG(NREG)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (ir_q[25:21]),
        .ra2_i (ir_q[20:16]),
        .rd1_o (rs_val_s),
        .rd2_o (rt_val_s),
        .we_i  (rf_we_s),
        .wa_i  (rf_wa_s),
        .wd_i  (rf_wd_s)
    );

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        mdr_d      = mdr_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        rf_we_s    = 1'b0;
        rf_wa_s    = ir_q[20:16];
        rf_wd_s    = alu_out_q;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                a_d       = rs_val_s;
                b_d       = rt_val_s;
                alu_out_d = pc_q + {sext_imm_s[29:0], 2'b00};
                if ((opcode_s == OP_J) || (opcode_s == OP_JAL)) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    rf_we_s = (opcode_s == OP_JAL);
                    rf_wa_s = 5'd31;
                    rf_wd_s = pc_q;
                    state_d = ST_FETCH;
                end else if (!is_legal(opcode_s, funct_s)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((opcode_s == OP_BEQ) || (opcode_s == OP_BNE)) begin
                    if ((a_q == b_q) == (opcode_s == OP_BEQ)) begin
                        pc_d = alu_out_q;
                    end else begin
                        pc_d = pc_q;
                    end
                    state_d = ST_FETCH;
                end else if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
                    alu_out_d = alu_res_s;
                    state_d   = ST_MEM;
                end else begin
                    alu_out_d = alu_res_s;
                    if (ovf_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
`ifdef MC_OVERFLOW_TRAP_EN
                    if (ovf_s) begin
                        pc_d    = TRAP_VECTOR;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
`else
                    state_d = ST_WB;
`endif
                end
            end
            ST_MEM: begin
                if (!mem.mem_ready) begin
                    state_d = ST_MEM;
                end else if (opcode_s == OP_SW) begin
                    state_d = ST_FETCH;
                end else begin
                    mdr_d   = mem.mem_rdata;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we_s = 1'b1;
                if (opcode_s == OP_RTYPE) begin
                    rf_wa_s = ir_q[15:11];
                end else if (opcode_s == OP_LW) begin
                    rf_wd_s = mdr_q;
                end else begin
                    rf_wa_s = ir_q[20:16];
                end
                state_d = ST_FETCH;
            end
            default: state_d = ST_RST;
        endcase
    end

    // Architectural state; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            a_q        <= 32'h0000_0000;
            b_q        <= 32'h0000_0000;
            alu_out_q  <= 32'h0000_0000;
            mdr_q      <= 32'h0000_0000;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_out_q  <= alu_out_d;
            mdr_q      <= mdr_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    // Bus outputs decode straight from registers, so they hold while waiting and drop with reset.
    assign mem.mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign mem.mem_we    = (state_q == ST_MEM) && (opcode_s == OP_SW);
    assign mem.mem_addr  = (state_q == ST_MEM) ? {alu_out_q[MEM_AW-1:2], 2'b00}
                                               : {pc_q[MEM_AW-1:2], 2'b00};
    assign mem.mem_wdata = b_q;

    assign PC_out   = pc_q;
    assign ALU_out  = alu_out_q;
    assign zero     = (alu_res_s == 32'h0000_0000);
    assign overflow = overflow_q;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_data_path.sv
// Self-checking bench for mc_data_path: word memory model with wait states and a store scoreboard.
`timescale 1ns/1ps
module tb_mc_data_path;
    import mc_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_out, ALU_out;
    logic        zero, overflow, illegal;
    logic [2:0]  state;

    logic [31:0] mem [128];
    int          stall_fetch, stall_mem, wcnt;
    int          checks = 0;
    int          errors = 0;
    st_t         exp_q[$];

    always #5 clk = ~clk;

    mc_data_path_if #(.MEM_AW(32)) bus();

    mc_data_path #(.RESET_PC(32'h0000_0000), .NREG(32), .MEM_AW(32)) dut (
        .clk(clk), .rst(rst), .mem(bus), .PC_out(PC_out), .ALU_out(ALU_out),
        .zero(zero), .overflow(overflow), .illegal(illegal), .state(state)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[8:2]];
    assign bus.mem_ready = (wcnt >= ((state == ST_MEM) ? stall_mem : stall_fetch));

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, f};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input int target);
        return {op, target[25:0]};
    endfunction

    // One clock; observe the cycle at the falling edge and score any completing store.
    task automatic step(input int n);
        st_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL store_unexpected got %h:%h want none", bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL store got %h:%h want %h:%h", bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            step(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending stores want 0", name, exp_q.size());
        end
    endtask

    task automatic start();
        rst = 1'b1;
        stall_fetch = 0;
        stall_mem = 0;
        exp_q.delete();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        start();
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.mem_req); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", PC_out); end
        checks++; if ({state, overflow, illegal} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 0", {state, overflow, illegal}); end
        checks++; if (ALU_out !== 32'h0) begin errors++; $display("FAIL rst_aluout got %h want 0", ALU_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({state, bus.mem_req} !== {ST_RST, 1'b0}) begin errors++; $display("FAIL rst_first_cycle got %b want %b", {state, bus.mem_req}, {ST_RST, 1'b0}); end
        step(1);
        checks++; if ({state, bus.mem_req, bus.mem_we} !== {ST_FETCH, 2'b10}) begin errors++; $display("FAIL first_fetch got %b want %b", {state, bus.mem_req, bus.mem_we}, {ST_FETCH, 2'b10}); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch_addr got %h want 0", bus.mem_addr); end
    endtask

    task automatic test_alu_seq();
        start();
        mem[0] = enc_i(OP_ADDI, 1, 1, 1);
        mem[1] = enc_r(1, 1, 2, F_ADD);
        mem[2] = enc_i(OP_SW, 0, 1, 32'h180);
        mem[3] = enc_i(OP_SW, 0, 2, 32'h184);
        mem[4] = enc_j(OP_J, 4);
        exp_q.push_back('{32'h180, 32'h1});
        exp_q.push_back('{32'h184, 32'h2});
        rst = 1'b0;
        step(5);
        checks++; if ({PC_out, ALU_out} !== {32'h4, 32'h1}) begin errors++; $display("FAIL addi_4cyc got %h/%h want 4/1", PC_out, ALU_out); end
        step(4);
        checks++; if ({PC_out, ALU_out} !== {32'h8, 32'h2}) begin errors++; $display("FAIL add_8cyc got %h/%h want 8/2", PC_out, ALU_out); end
        checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL add_state got %0d want %0d", state, ST_FETCH); end
        drain("alu_seq", 60);
    endtask

    task automatic test_alu_ops();
        logic [31:0] expv [10];
        expv = '{32'h0000_F0F0, 32'hFFFF_FFFD, 32'h0000_F0F3, 32'h1, 32'h0,
                 32'h0000_8001, 32'h0000_8000, 32'h1, 32'hFFFF_8000, 32'h0};
        start();
        mem[0]  = enc_i(OP_ORI, 0, 1, 32'hF0F0);
        mem[1]  = enc_i(OP_ADDI, 0, 2, -3);
        mem[2]  = enc_r(1, 2, 3, F_AND);
        mem[3]  = enc_r(1, 2, 4, F_OR);
        mem[4]  = enc_r(1, 2, 5, F_SUB);
        mem[5]  = enc_r(2, 1, 6, F_SLT);
        mem[6]  = enc_r(1, 2, 7, F_SLT);
        mem[7]  = enc_i(OP_ANDI, 2, 8, 32'h8001);
        mem[8]  = enc_i(OP_ORI, 0, 9, 32'h8000);
        mem[9]  = enc_i(OP_SLTI, 2, 10, -2);
        mem[10] = enc_i(OP_ADDI, 0, 11, -32768);
        mem[11] = enc_i(OP_ADDI, 0, 0, 5);
        for (int k = 0; k < 9; k++) mem[12 + k] = enc_i(OP_SW, 0, 3 + k, 32'h180 + 4 * k);
        mem[21] = enc_i(OP_SW, 0, 0, 32'h1A4);
        mem[22] = enc_j(OP_J, 22);
        for (int k = 0; k < 10; k++) exp_q.push_back('{32'h180 + 4 * k, expv[k]});
        rst = 1'b0;
        drain("alu_ops", 300);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL alu_ops_no_ovf got %b want 0", overflow); end
    endtask

    task automatic test_lw_wait();
        int  mem_cycles;
        logic bad;
        start();
        mem[0]  = enc_j(OP_J, 16);
        mem[1]  = 32'hDEAD_BEEF;
        mem[16] = enc_i(OP_LW, 0, 3, 4);
        mem[17] = enc_i(OP_SW, 0, 3, 32'h180);
        mem[18] = enc_j(OP_J, 18);
        stall_mem = 3;
        exp_q.push_back('{32'h180, 32'hDEAD_BEEF});
        rst = 1'b0;
        step(3);
        checks++; if (PC_out !== 32'h40) begin errors++; $display("FAIL lw_start_pc got %h want 40", PC_out); end
        mem_cycles = 0;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (state == ST_MEM) begin
                mem_cycles++;
                if ((bus.mem_addr !== 32'h4) || (bus.mem_req !== 1'b1) || (bus.mem_we !== 1'b0)) bad = 1'b1;
            end
        end
        checks++; if (mem_cycles != 4) begin errors++; $display("FAIL lw_mem_cycles got %0d want 4", mem_cycles); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL lw_addr_stable got %b want 0", bad); end
        checks++; if ({state, PC_out, ALU_out} !== {ST_FETCH, 32'h44, 32'h4}) begin errors++; $display("FAIL lw_8cyc got %0d/%h/%h want 1/44/4", state, PC_out, ALU_out); end
        drain("lw", 60);
    endtask

    task automatic test_branch();
        start();
        mem[0] = enc_j(OP_J, 4);
        mem[4] = enc_i(OP_BEQ, 1, 1, -1);
        rst = 1'b0;
        step(3);
        checks++; if (PC_out !== 32'h10) begin errors++; $display("FAIL beq_pre_pc got %h want 10", PC_out); end
        step(3);
        checks++; if ({state, PC_out} !== {ST_FETCH, 32'h10}) begin errors++; $display("FAIL beq_taken got %0d/%h want 1/10", state, PC_out); end
        start();
        mem[0] = enc_j(OP_J, 4);
        mem[4] = enc_i(OP_BNE, 1, 1, -1);
        mem[5] = enc_j(OP_J, 5);
        rst = 1'b0;
        step(6);
        checks++; if ({state, PC_out} !== {ST_FETCH, 32'h14}) begin errors++; $display("FAIL bne_not_taken got %0d/%h want 1/14", state, PC_out); end
        start();
        mem[0] = enc_i(OP_ADDI, 0, 1, 1);
        mem[1] = enc_i(OP_BNE, 1, 0, 2);
        mem[2] = enc_j(OP_J, 2);
        mem[4] = enc_j(OP_J, 4);
        rst = 1'b0;
        step(8);
        checks++; if (PC_out !== 32'h10) begin errors++; $display("FAIL bne_taken got %h want 10", PC_out); end
    endtask

    task automatic test_jal();
        start();
        mem[0]  = enc_j(OP_J, 8);
        mem[8]  = enc_j(OP_JAL, 32'h40);
        mem[64] = enc_i(OP_SW, 0, 31, 32'h180);
        mem[65] = enc_j(OP_J, 65);
        exp_q.push_back('{32'h180, 32'h24});
        rst = 1'b0;
        step(3);
        checks++; if (PC_out !== 32'h20) begin errors++; $display("FAIL jal_pre_pc got %h want 20", PC_out); end
        step(2);
        checks++; if ({state, PC_out} !== {ST_FETCH, 32'h100}) begin errors++; $display("FAIL jal_2cyc got %0d/%h want 1/100", state, PC_out); end
        drain("jal", 40);
    endtask

    task automatic test_overflow();
        start();
        mem[0]   = enc_i(OP_LW, 0, 5, 32'h1F0);
        mem[124] = 32'h7FFF_FFFF;
        mem[1]   = enc_i(OP_ADDI, 5, 4, 1);
        mem[2]   = enc_i(OP_SW, 0, 4, 32'h180);
        mem[3]   = enc_j(OP_J, 3);
        mem[32]  = enc_i(OP_SW, 0, 4, 32'h184);
        mem[33]  = enc_j(OP_J, 33);
`ifdef MC_OVERFLOW_TRAP_EN
        exp_q.push_back('{32'h184, 32'h0});
`else
        exp_q.push_back('{32'h180, 32'h8000_0000});
`endif
        rst = 1'b0;
        step(6);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", overflow); end
        drain("overflow", 100);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
`ifdef MC_OVERFLOW_TRAP_EN
        checks++; if (PC_out !== 32'h84) begin errors++; $display("FAIL ovf_trap_pc got %h want 84", PC_out); end
`else
        checks++; if (PC_out !== 32'hC) begin errors++; $display("FAIL ovf_wrap_pc got %h want c", PC_out); end
`endif
    endtask

    task automatic test_reset_illegal();
        start();
        stall_fetch = 100;
        rst = 1'b0;
        step(3);
        checks++; if ({state, bus.mem_req} !== {ST_FETCH, 1'b1}) begin errors++; $display("FAIL fetch_wait got %b want %b", {state, bus.mem_req}, {ST_FETCH, 1'b1}); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.mem_req, state, PC_out} !== {1'b0, ST_RST, 32'h0}) begin errors++; $display("FAIL rst_abort got %b/%0d/%h want 0/0/0", bus.mem_req, state, PC_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_clears_ovf got %b want 0", overflow); end
        @(negedge clk);
        stall_fetch = 0;
        mem[0] = 32'hFC00_0000;
        mem[1] = enc_j(OP_J, 1);
        rst = 1'b0;
        step(1);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_before got %b want 0", illegal); end
        step(2);
        checks++; if ({illegal, PC_out, bus.mem_addr} !== {1'b1, 32'h4, 32'h4}) begin errors++; $display("FAIL illegal_op got %b/%h/%h want 1/4/4", illegal, PC_out, bus.mem_addr); end
        start();
        mem[0] = enc_r(1, 2, 3, 6'h00);
        mem[1] = enc_j(OP_J, 1);
        rst = 1'b0;
        step(3);
        checks++; if ({illegal, PC_out} !== {1'b1, 32'h4}) begin errors++; $display("FAIL illegal_funct got %b/%h want 1/4", illegal, PC_out); end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_alu_ops();
        test_lw_wait();
        test_branch();
        test_jal();
        test_overflow();
        test_reset_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
